// File: rtl/reg_file_mp.sv
// ============================================================================
// Module   : reg_file_mp
// Brief    : Parametrised register file, one synchronous write port, two
//            registered read ports, write-first bypass, optional hard-wired
//            zero entry and a one-entry-per-cycle clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              clr,
  output logic              busy
);

  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam bit                ZR       = (ZERO_REG != 0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic clr_acc;
  logic wr_acc;
  logic waddr_ok;
  logic raddr_a_ok;
  logic raddr_b_ok;

  // A clr request wins over a write in the same cycle, and nothing is
  // written while the sweep owns the array.
  always_comb begin
    clr_acc    = (state == IDLE) && clr;
    waddr_ok   = ({1'b0, waddr} < DEPTH_W) && !(ZR && (waddr == '0));
    raddr_a_ok = ({1'b0, raddr_a} < DEPTH_W) && !(ZR && (raddr_a == '0));
    raddr_b_ok = ({1'b0, raddr_b} < DEPTH_W) && !(ZR && (raddr_b == '0));
    wr_acc     = we && (state == IDLE) && !clr && waddr_ok;
  end

  // Clear sequencer: busy is the registered image of the CLEAR state.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          // The pointer holds at the last entry instead of wrapping.
          if (ptr == LAST_PTR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: sweep clears one entry per cycle, otherwise normal writes.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_acc) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read ports with write-first bypass; zero while clearing.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if ((state == CLEAR) || clr_acc || !raddr_a_ok) begin
        rdata_a <= '0;
      end else if (wr_acc && (waddr == raddr_a)) begin
        rdata_a <= wdata;
      end else begin
        rdata_a <= mem[raddr_a];
      end

      if ((state == CLEAR) || clr_acc || !raddr_b_ok) begin
        rdata_b <= '0;
      end else if (wr_acc && (waddr == raddr_b)) begin
        rdata_b <= wdata;
      end else begin
        rdata_b <= mem[raddr_b];
      end
    end
  end

endmodule

`default_nettype wire
